// File: rtl/fpmul_pkg.sv
// Shared types for the fpmul operand scheduler.
// Holds FSM encoding, idle-slot constants and credit depth.
package fpmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic NO_IDLE  = 1'b0;
  localparam logic PUT_IDLE = 1'b1;

  localparam logic [1:0] CRED_MAX = 2'd2;

endpackage

// File: rtl/fpmul_sched_res_fifo2.sv
// Two-entry result FIFO for one requester.
// Write and pop in the same cycle both take effect.
module res_fifo2 #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;
  logic         w_rd;

  assign w_rd    = i_rd && (r_cnt != 2'd0);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (i_wr) r_wptr <= ~r_wptr;
      if (w_rd) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, i_wr}
                     - {1'b0, w_rd};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/fpmul_sched.sv
// Two-requester scheduler for a shared fixed-latency multiplier.
// Credit-limited round-robin issue, tag pipe, per-requester FIFOs.
module fpmul_sched
  import fpmul_pkg::*;
#(
  parameter int LAT = 5,
  parameter int W   = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         res0_valid,
  input  logic         res0_ready,
  output logic [W-1:0] res0_data,
  output logic         res1_valid,
  input  logic         res1_ready,
  output logic [W-1:0] res1_data,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  output logic         mul_idle,
  input  logic [W-1:0] mul_product,
  input  logic         flush,
  output logic         flush_done,
  output logic         busy
);

  state_t         r_state;
  state_t         w_state_n;
  logic [1:0]     r_cred0;
  logic [1:0]     r_cred1;
  logic [1:0]     w_cred0_n;
  logic [1:0]     w_cred1_n;
  logic           r_last;
  logic           w_last_n;
  logic           r_rdy0;
  logic           r_rdy1;
  logic           w_e0;
  logic           w_e1;
  logic           w_done_n;
  logic           r_flush_done;
  logic [W-1:0]   r_mul_a;
  logic [W-1:0]   r_mul_b;
  logic           r_mul_idle;
  logic           r_slot_v;
  logic           r_slot_id;
  logic [LAT-1:0] r_tag_v;
  logic [LAT-1:0] r_tag_id;
  logic           w_iss0;
  logic           w_iss1;
  logic           w_iss;
  logic           w_pop0;
  logic           w_pop1;
  logic           w_wr0;
  logic           w_wr1;
  logic           w_empty;

  assign w_iss0 = req0_valid && r_rdy0;
  assign w_iss1 = req1_valid && r_rdy1;
  assign w_iss  = w_iss0 || w_iss1;
  assign w_pop0 = res0_valid && res0_ready;
  assign w_pop1 = res1_valid && res1_ready;

  assign w_wr0 = r_tag_v[LAT-1] && !r_tag_id[LAT-1];
  assign w_wr1 = r_tag_v[LAT-1] &&  r_tag_id[LAT-1];

  assign w_empty = !r_slot_v && (r_tag_v == '0)
                && !res0_valid && !res1_valid;

  assign req0_ready = r_rdy0;
  assign req1_ready = r_rdy1;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign mul_idle   = r_mul_idle;
  assign flush_done = r_flush_done;
  assign busy       = (r_state != S_IDLE);

  always_comb begin
    w_state_n = r_state;
    w_done_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (flush)      w_state_n = S_DRAIN;
        else if (w_iss) w_state_n = S_RUN;
      end
      S_RUN: begin
        if (flush) w_state_n = S_DRAIN;
        else if (w_empty && !w_iss)
          w_state_n = S_IDLE;
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_cred0_n = r_cred0 - {1'b0, w_iss0}
                             + {1'b0, w_pop0};
  assign w_cred1_n = r_cred1 - {1'b0, w_iss1}
                             + {1'b0, w_pop1};

  // An offer counts as a turn whether or not it was taken,
  // so an idle requester never blocks the other one.
  assign w_last_n = r_rdy1 ? 1'b1
                  : (r_rdy0 ? 1'b0 : r_last);

  assign w_e0 = (w_state_n != S_DRAIN)
             && (w_cred0_n != 2'd0);
  assign w_e1 = (w_state_n != S_DRAIN)
             && (w_cred1_n != 2'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cred0      <= CRED_MAX;
      r_cred1      <= CRED_MAX;
      r_last       <= 1'b1;
      r_rdy0       <= 1'b0;
      r_rdy1       <= 1'b0;
      r_flush_done <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_idle   <= PUT_IDLE;
      r_slot_v     <= 1'b0;
      r_slot_id    <= 1'b0;
      r_tag_v      <= '0;
      r_tag_id     <= '0;
    end else begin
      r_state      <= w_state_n;
      r_cred0      <= w_cred0_n;
      r_cred1      <= w_cred1_n;
      r_last       <= w_last_n;
      r_rdy0       <= w_e0 && (!w_e1 || w_last_n);
      r_rdy1       <= w_e1 && (!w_e0 || !w_last_n);
      r_flush_done <= w_done_n;
      if (w_iss) begin
        r_mul_a    <= w_iss1 ? req1_a : req0_a;
        r_mul_b    <= w_iss1 ? req1_b : req0_b;
        r_mul_idle <= NO_IDLE;
      end else begin
        r_mul_idle <= PUT_IDLE;
      end
      r_slot_v  <= w_iss;
      r_slot_id <= w_iss1;
      r_tag_v   <= {r_tag_v[LAT-2:0], r_slot_v};
      r_tag_id  <= {r_tag_id[LAT-2:0], r_slot_id};
    end
  end

  res_fifo2 #(.W(W)) u_fifo0 (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_wr    (w_wr0),
    .i_wdata (mul_product),
    .i_rd    (res0_ready),
    .o_valid (res0_valid),
    .o_data  (res0_data)
  );

  res_fifo2 #(.W(W)) u_fifo1 (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_wr    (w_wr1),
    .i_wdata (mul_product),
    .i_rd    (res1_ready),
    .o_valid (res1_valid),
    .o_data  (res1_data)
  );

endmodule

// File: tb/tb_fpmul_sched.sv
// Directed bench for fpmul_sched with a LAT-stage
// single-precision multiplier model.
module tb_fpmul_sched;

  localparam int LAT = 5;
  localparam int W   = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0;
  logic [W-1:0] req1_a = '0, req1_b = '0;
  logic         res0_valid, res1_valid;
  logic         res0_ready = 1'b0, res1_ready = 1'b0;
  logic [W-1:0] res0_data, res1_data;
  logic [W-1:0] mul_a, mul_b, mul_product;
  logic         mul_idle;
  logic         flush = 1'b0;
  logic         flush_done, busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          g[$];

  logic [31:0] ca0 [4] = '{32'h40000000, 32'h3FC00000,
                           32'h40800000, 32'hC0000000};
  logic [31:0] cb0 [4] = '{32'h40400000, 32'h40000000,
                           32'h3F000000, 32'h40400000};
  logic [31:0] ce0 [4] = '{32'h40C00000, 32'h40400000,
                           32'h40000000, 32'hC0C00000};
  logic [31:0] ca1 [4] = '{32'h3F800000, 32'h40A00000,
                           32'h40400000, 32'h3E800000};
  logic [31:0] cb1 [4] = '{32'h3F800000, 32'h40000000,
                           32'h40400000, 32'h40800000};
  logic [31:0] ce1 [4] = '{32'h3F800000, 32'h41200000,
                           32'h41100000, 32'h3F800000};

  always #5 clock = ~clock;

  fpmul_sched #(.LAT(LAT), .W(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .res0_valid  (res0_valid),
    .res0_ready  (res0_ready),
    .res0_data   (res0_data),
    .res1_valid  (res1_valid),
    .res1_ready  (res1_ready),
    .res1_data   (res1_data),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_idle    (mul_idle),
    .mul_product (mul_product),
    .flush       (flush),
    .flush_done  (flush_done),
    .busy        (busy)
  );

  // Normal-number single-precision multiply, round to nearest even.
  function automatic logic [31:0] fmul(input logic [31:0] a,
                                      input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] ma, mb, m;
    logic [24:0] r;
    logic        gb, st;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    m  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      e++;
      r = {1'b0, m[47:24]}; gb = m[23]; st = |m[22:0];
    end else begin
      r = {1'b0, m[46:23]}; gb = m[22]; st = |m[21:0];
    end
    if (gb && (st || r[0])) r = r + 25'd1;
    if (r[24]) begin r = r >> 1; e++; end
    return {s, e[7:0], r[22:0]};
  endfunction

  logic [W-1:0] mp [LAT];
  always @(posedge clock) begin
    mp[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_product = mp[LAT-1];

  always @(negedge clock) begin
    if (res0_valid && res0_ready) q0.push_back(res0_data);
    if (res1_valid && res1_ready) q1.push_back(res1_data);
    if (req0_valid && req0_ready) g.push_back(0);
    if (req1_valid && req1_ready) g.push_back(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; flush = 0;
    res0_ready = 0; res1_ready = 0;
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    tick();
    q0.delete(); q1.delete(); g.delete();
  endtask

  task automatic test_reset();
    req0_valid = 0; req1_valid = 0; flush = 0;
    reset_n = 0;
    tick(); tick();
    total++;
    if ({mul_idle, mul_a, mul_b} !== {1'b1, 64'd0}) begin
      bad++;
      $display("FAIL rst_mul got=%b/%h/%h exp=1/0/0", mul_idle, mul_a, mul_b);
    end
    total++;
    if ({req0_ready, req1_ready, res0_valid, res1_valid} !== 4'b0) begin
      bad++;
      $display("FAIL rst_hs got=%b%b%b%b exp=0000",
               req0_ready, req1_ready, res0_valid, res1_valid);
    end
    total++;
    if ({flush_done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL rst_fsm got=%b%b exp=00", flush_done, busy);
    end
    reset_n = 1;
    tick();
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL rst_first_grant got=%b%b exp=10", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    res0_ready = 1;
    req0_a = 32'h40000000; req0_b = 32'h40400000; req0_valid = 1;
    n = 0;
    while (!req0_ready && n < 10) begin tick(); n++; end
    tick();
    req0_valid = 0;
    total++;
    if ({mul_idle, mul_a, mul_b} !== {1'b0, 32'h40000000, 32'h40400000}) begin
      bad++;
      $display("FAIL single_issue got=%b/%h/%h exp=0/40000000/40400000",
               mul_idle, mul_a, mul_b);
    end
    tick();
    n = 1;
    total++;
    if ({mul_idle, mul_a} !== {1'b1, 32'h40000000}) begin
      bad++;
      $display("FAIL single_hold got=%b/%h exp=1/40000000", mul_idle, mul_a);
    end
    while (!res0_valid && n < 20) begin tick(); n++; end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL single_latency got=%0d exp=6", n);
    end
    total++;
    if (res0_data !== 32'h40C00000) begin
      bad++;
      $display("FAIL single_data got=%h exp=40C00000", res0_data);
    end
    tick(); tick(); tick();
    total++;
    if ({busy, res0_valid} !== 2'b00) begin
      bad++;
      $display("FAIL single_idle got=%b%b exp=00", busy, res0_valid);
    end
  endtask

  task automatic test_contention();
    int   i0, i1, n;
    logic a0, a1;
    do_reset();
    res0_ready = 1; res1_ready = 1;
    i0 = 0; i1 = 0;
    req0_a = ca0[0]; req0_b = cb0[0];
    req1_a = ca1[0]; req1_b = cb1[0];
    req0_valid = 1; req1_valid = 1;
    n = 0;
    while ((i0 < 4 || i1 < 4) && n < 200) begin
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      tick(); n++;
      if (a0) begin
        i0++;
        if (i0 < 4) begin req0_a = ca0[i0]; req0_b = cb0[i0]; end
        else req0_valid = 0;
      end
      if (a1) begin
        i1++;
        if (i1 < 4) begin req1_a = ca1[i1]; req1_b = cb1[i1]; end
        else req1_valid = 0;
      end
    end
    n = 0;
    while ((q0.size() < 4 || q1.size() < 4) && n < 60) begin tick(); n++; end
    total++;
    if (i0 != 4 || i1 != 4 || q0.size() != 4 || q1.size() != 4) begin
      bad++;
      $display("FAIL cont_count got=%0d/%0d/%0d/%0d exp=4/4/4/4",
               i0, i1, q0.size(), q1.size());
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (g.size() <= k || g[k] != (k % 2)) begin
        bad++;
        $display("FAIL cont_grant%0d got=%0d exp=%0d", k,
                 (g.size() > k) ? g[k] : -1, k % 2);
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (q0.size() <= k || q0[k] !== ce0[k]) begin
        bad++;
        $display("FAIL cont_res0_%0d got=%h exp=%h", k,
                 (q0.size() > k) ? q0[k] : 32'hx, ce0[k]);
      end
      total++;
      if (q1.size() <= k || q1[k] !== ce1[k]) begin
        bad++;
        $display("FAIL cont_res1_%0d got=%h exp=%h", k,
                 (q1.size() > k) ? q1[k] : 32'hx, ce1[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int   i0, iss1, late, n;
    logic a0;
    do_reset();
    res0_ready = 1; res1_ready = 0;
    i0 = 0; iss1 = 0; late = 0;
    req0_a = ca0[0]; req0_b = cb0[0];
    req1_a = 32'h40000000; req1_b = 32'h40000000;
    req0_valid = 1; req1_valid = 1;
    for (int c = 0; c < 60; c++) begin
      if (iss1 >= 2 && req1_ready) late++;
      a0 = req0_valid && req0_ready;
      if (req1_valid && req1_ready) iss1++;
      tick();
      if (a0) begin
        i0++;
        if (i0 < 4) begin req0_a = ca0[i0]; req0_b = cb0[i0]; end
        else req0_valid = 0;
      end
    end
    total++;
    if (iss1 != 2) begin
      bad++;
      $display("FAIL bp_req1_issues got=%0d exp=2", iss1);
    end
    total++;
    if (late != 0 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_req1_ready got=%0d/%b exp=0/0", late, req1_ready);
    end
    total++;
    if (i0 != 4 || q0.size() != 4) begin
      bad++;
      $display("FAIL bp_req0_flow got=%0d/%0d exp=4/4", i0, q0.size());
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (q0.size() <= k || q0[k] !== ce0[k]) begin
        bad++;
        $display("FAIL bp_res0_%0d got=%h exp=%h", k,
                 (q0.size() > k) ? q0[k] : 32'hx, ce0[k]);
      end
    end
    req1_valid = 0;
    res1_ready = 1;
    n = 0;
    while (q1.size() < 2 && n < 10) begin tick(); n++; end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (q1.size() <= k || q1[k] !== 32'h40800000) begin
        bad++;
        $display("FAIL bp_res1_%0d got=%h exp=40800000", k,
                 (q1.size() > k) ? q1[k] : 32'hx);
      end
    end
  endtask

  task automatic test_flush();
    int          iss, n, late, dn, done_at, last_pop;
    logic [29:0] bh;
    do_reset();
    res0_ready = 1; res1_ready = 1;
    req0_a = 32'h3FC00000; req0_b = 32'h40000000;
    req1_a = 32'h40A00000; req1_b = 32'h40000000;
    req0_valid = 1; req1_valid = 1;
    iss = 0; n = 0;
    while (iss < 3 && n < 20) begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        iss++;
        if (iss == 3) flush = 1;
      end
      tick();
      flush = 0;
      n++;
    end
    total++;
    if ({busy, req0_ready, req1_ready} !== 3'b100) begin
      bad++;
      $display("FAIL flush_enter got=%b%b%b exp=100", busy, req0_ready, req1_ready);
    end
    late = 0; dn = 0; done_at = -1; last_pop = -10; bh = '0;
    for (int c = 0; c < 30; c++) begin
      bh[c] = busy;
      if (flush_done) begin
        dn++; done_at = c;
        req0_valid = 0; req1_valid = 0;
      end else if (dn == 0) begin
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) late++;
        if (res0_valid || res1_valid) last_pop = c;
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    total++;
    if (late != 0) begin
      bad++;
      $display("FAIL flush_no_grant got=%0d exp=0", late);
    end
    total++;
    if (dn != 1 || done_at != last_pop + 2) begin
      bad++;
      $display("FAIL flush_done_pulse got=%0d@%0d exp=1@%0d", dn, done_at, last_pop + 2);
    end
    total++;
    if (done_at < 1 || bh[done_at] !== 1'b0 || bh[done_at-1] !== 1'b1) begin
      bad++;
      $display("FAIL flush_busy_drop got_at=%0d exp_at=%0d", done_at, last_pop + 2);
    end
    total++;
    if (q0.size() != 2 || q1.size() != 1) begin
      bad++;
      $display("FAIL flush_results got=%0d/%0d exp=2/1", q0.size(), q1.size());
    end else begin
      total++;
      if ({q0[0], q0[1], q1[0]} !== {32'h40400000, 32'h40400000, 32'h41200000}) begin
        bad++;
        $display("FAIL flush_data got=%h/%h/%h exp=40400000/40400000/41200000",
                 q0[0], q0[1], q1[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, seen, iss0;
    do_reset();
    res0_ready = 1;
    req0_a = 32'h40000000; req0_b = 32'h40400000; req0_valid = 1;
    n = 0;
    while (!req0_ready && n < 10) begin tick(); n++; end
    tick();
    req0_valid = 0;
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (res0_valid || res1_valid) seen++;
      tick();
    end
    total++;
    if (seen != 0 || q0.size() != 0) begin
      bad++;
      $display("FAIL rmid_no_result got=%0d/%0d exp=0/0", seen, q0.size());
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_busy got=%b exp=0", busy);
    end
    res0_ready = 0;
    req0_a = 32'h40800000; req0_b = 32'h3F000000; req0_valid = 1;
    iss0 = 0;
    for (int c = 0; c < 20; c++) begin
      if (req0_valid && req0_ready) iss0++;
      tick();
    end
    req0_valid = 0;
    total++;
    if (iss0 != 2) begin
      bad++;
      $display("FAIL rmid_credits got=%0d exp=2", iss0);
    end
    res0_ready = 1;
    n = 0;
    while (q0.size() < 2 && n < 15) begin tick(); n++; end
    total++;
    if (q0.size() != 2) begin
      bad++;
      $display("FAIL rmid_pops got=%0d exp=2", q0.size());
    end else begin
      total++;
      if ({q0[0], q0[1]} !== {32'h40000000, 32'h40000000}) begin
        bad++;
        $display("FAIL rmid_data got=%h/%h exp=40000000/40000000", q0[0], q0[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
